// File: rtl/complete_arb.sv
// Complete stage: per-FU result FIFOs merged onto CDB_W broadcast/writeback ports by round-robin.
// Optional macro COMPLETE_BYPASS_EN lets an empty channel's incoming result win arbitration directly.
module complete_arb #(
  parameter int NUM_FU  = 4,
  parameter int CDB_W   = 1,
  parameter int Q_DEPTH = 2,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    squash_i,
  input  logic [NUM_FU-1:0]       ex_valid_i,
  input  logic [NUM_FU*XLEN-1:0]  ex_npc_i,
  input  logic [NUM_FU-1:0]       ex_take_branch_i,
  input  logic [NUM_FU*XLEN-1:0]  ex_alu_result_i,
  input  logic [NUM_FU*5-1:0]     ex_dest_reg_idx_i,
  input  logic [NUM_FU*TAG_W-1:0] ex_tag_i,
  output logic [NUM_FU-1:0]       ex_ready_o,
  output logic [CDB_W-1:0]        cdb_valid_o,
  output logic [CDB_W-1:0]        cdb_done_o,
  output logic [CDB_W-1:0]        cdb_halt_o,
  output logic [CDB_W-1:0]        cdb_illegal_o,
  output logic [CDB_W*XLEN-1:0]   cdb_value_o,
  output logic [CDB_W*XLEN-1:0]   cdb_npc_o,
  output logic [CDB_W-1:0]        cdb_take_branch_o,
  output logic [CDB_W*5-1:0]      cdb_dest_reg_idx_o,
  output logic [CDB_W*TAG_W-1:0]  cdb_tag_o,
  output logic [CDB_W-1:0]        wb_regfile_en_o,
  output logic [CDB_W*5-1:0]      wb_regfile_idx_o,
  output logic [CDB_W*XLEN-1:0]   wb_regfile_data_o
);

  localparam int CNT_W = $clog2(Q_DEPTH + 1);
  localparam int QP_W  = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [4:0] ZERO_REG = 5'd0;

  // Entry layout, LSB first: tag, dest, alu_result, take_branch, npc
  localparam int DST_B = TAG_W;
  localparam int ALU_B = TAG_W + 5;
  localparam int TB_B  = TAG_W + 5 + XLEN;
  localparam int NPC_B = TAG_W + 6 + XLEN;
  localparam int ENT_W = NPC_B + XLEN;

  logic [ENT_W-1:0] mem_q [NUM_FU][Q_DEPTH];
  logic [QP_W-1:0]  rd_ptr_q [NUM_FU];
  logic [QP_W-1:0]  rd_ptr_d [NUM_FU];
  logic [QP_W-1:0]  wr_ptr_q [NUM_FU];
  logic [QP_W-1:0]  wr_ptr_d [NUM_FU];
  logic [CNT_W-1:0] cnt_q [NUM_FU];
  logic [CNT_W-1:0] cnt_d [NUM_FU];
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [ENT_W-1:0] ex_ent [NUM_FU];
  logic [ENT_W-1:0] head [NUM_FU];
  logic [NUM_FU-1:0] cand, grant, push, pop, byp_take;

  logic [CDB_W-1:0] port_vld;
  logic [ENT_W-1:0] port_ent [CDB_W];
  logic [CDB_W-1:0] out_vld_q;
  logic [ENT_W-1:0] out_ent_q [CDB_W];

  function automatic logic [QP_W-1:0] ptr_inc(input logic [QP_W-1:0] p);
    return (p == QP_W'(Q_DEPTH - 1)) ? '0 : p + QP_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      ex_ent[i] = {ex_npc_i[i*XLEN +: XLEN], ex_take_branch_i[i],
                   ex_alu_result_i[i*XLEN +: XLEN], ex_dest_reg_idx_i[i*5 +: 5],
                   ex_tag_i[i*TAG_W +: TAG_W]};
      ex_ready_o[i] = (cnt_q[i] < CNT_W'(Q_DEPTH)) && !reset_i;
      cand[i] = (cnt_q[i] != '0);
      head[i] = mem_q[i][rd_ptr_q[i]];
`ifdef COMPLETE_BYPASS_EN
      // An empty channel offers its live input; a non-empty one must drain in order first.
      if ((cnt_q[i] == '0) && ex_valid_i[i] && ex_ready_o[i]) begin
        cand[i] = 1'b1;
        head[i] = ex_ent[i];
      end
`endif
    end
  end

  always_comb begin : arb
    int n;
    int idx;
    n = 0;
    idx = 0;
    grant = '0;
    port_vld = '0;
    rr_ptr_d = rr_ptr_q;
    for (int p = 0; p < CDB_W; p++) port_ent[p] = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (cand[idx] && (n < CDB_W)) begin
        grant[idx]  = 1'b1;
        port_vld[n] = 1'b1;
        port_ent[n] = head[idx];
        rr_ptr_d    = (idx == NUM_FU - 1) ? '0 : PTR_W'(idx + 1);
        n = n + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      byp_take[i] = grant[i] && (cnt_q[i] == '0);
      pop[i]      = grant[i] && (cnt_q[i] != '0);
      push[i]     = ex_valid_i[i] && ex_ready_o[i] && !squash_i && !byp_take[i];
      cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      wr_ptr_d[i] = push[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
      rd_ptr_d[i] = pop[i]  ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        cnt_q[i]    <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
      out_vld_q <= '0;
      for (int p = 0; p < CDB_W; p++) out_ent_q[p] <= '0;
    end else if (squash_i) begin
      // Flush everything but keep the round-robin position
      for (int i = 0; i < NUM_FU; i++) begin
        cnt_q[i]    <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
      out_vld_q <= '0;
      for (int p = 0; p < CDB_W; p++) out_ent_q[p] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int i = 0; i < NUM_FU; i++) begin
        cnt_q[i]    <= cnt_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
      end
      out_vld_q <= port_vld;
      for (int p = 0; p < CDB_W; p++) out_ent_q[p] <= port_ent[p];
    end
  end

  always_ff @(posedge clock_i) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= ex_ent[i];
    end
  end

  // Ungranted ports hold an all-zero entry, so every derived field reads 0
  always_comb begin
    cdb_valid_o        = '0;
    cdb_done_o         = '0;
    cdb_halt_o         = '0;
    cdb_illegal_o      = '0;
    cdb_value_o        = '0;
    cdb_npc_o          = '0;
    cdb_take_branch_o  = '0;
    cdb_dest_reg_idx_o = '0;
    cdb_tag_o          = '0;
    wb_regfile_en_o    = '0;
    wb_regfile_idx_o   = '0;
    wb_regfile_data_o  = '0;
    for (int p = 0; p < CDB_W; p++) begin
      cdb_valid_o[p]                 = out_vld_q[p];
      cdb_done_o[p]                  = out_vld_q[p];
      cdb_take_branch_o[p]           = out_ent_q[p][TB_B];
      cdb_npc_o[p*XLEN +: XLEN]      = out_ent_q[p][NPC_B +: XLEN];
      cdb_value_o[p*XLEN +: XLEN]    = out_ent_q[p][TB_B] ? out_ent_q[p][NPC_B +: XLEN]
                                                          : out_ent_q[p][ALU_B +: XLEN];
      cdb_dest_reg_idx_o[p*5 +: 5]   = out_ent_q[p][DST_B +: 5];
      cdb_tag_o[p*TAG_W +: TAG_W]    = out_ent_q[p][TAG_W-1:0];
      wb_regfile_en_o[p]             = out_vld_q[p] && (out_ent_q[p][DST_B +: 5] != ZERO_REG);
      wb_regfile_idx_o[p*5 +: 5]     = out_ent_q[p][DST_B +: 5];
      wb_regfile_data_o[p*XLEN +: XLEN] = cdb_value_o[p*XLEN +: XLEN];
    end
  end

endmodule
